// File: rtl/magic_nmi_ctrl_pkg.sv
// Shared types and constants for the magic (service-ROM) NMI controller.
package magic_nmi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    MAPPED,
    UNMAP,
    REENT
  } magic_state_t;

  localparam logic [7:0] CFG_IDX_CAUSE = 8'hFE;

endpackage

// File: rtl/magic_nmi_ctrl_if.sv
// CPU bus as seen by the magic controller; master drives, slave observes.
interface cpu_bus;

  logic [15:0] a;
  logic [7:0]  d;
  logic        mreq;
  logic        ioreq;
  logic        rd;
  logic        wr;
  logic        m1;

  modport master (output a, d, mreq, ioreq, rd, wr, m1);
  modport slave  (input  a, d, mreq, ioreq, rd, wr, m1);

endinterface

// File: rtl/magic_nmi_ctrl_cfg_regs.sv
// Config register file with I/O readback; writes visible next cycle, readback data registered (1 cycle).
module magic_cfg_regs
  import magic_nmi_ctrl_pkg::*;
#(
  parameter int                 NREGS     = 16,
  parameter logic [NREGS*8-1:0] CFG_RESET = '0
) (
  input  logic               clk28,
  input  logic               rst,
  input  logic               cs,
  input  logic               rd,
  input  logic               wr,
  input  logic [7:0]         idx,
  input  logic [7:0]         wdat,
  input  logic [7:0]         cause_byte,
  output logic [NREGS*8-1:0] cfg,
  output logic [7:0]         d_out,
  output logic               d_out_active
);

  localparam logic [8:0] NREGS_W = 9'(NREGS);

  logic [NREGS*8-1:0] cfg_q, cfg_d;
  logic [7:0]         d_out_q, d_out_d;
  logic               d_out_active_q, d_out_active_d;
  logic               idx_ok;

  always_comb begin
    idx_ok         = ({1'b0, idx} < NREGS_W);
    cfg_d          = cfg_q;
    d_out_d        = 8'hFF;
    d_out_active_d = cs && rd;

    if (cs && wr && idx_ok) begin
      cfg_d[{idx, 3'b000} +: 8] = wdat;
    end

    // Readback uses the pre-write image, so a same-cycle write is not reflected.
    if (cs && rd) begin
      if (idx_ok) begin
        d_out_d = cfg_q[{idx, 3'b000} +: 8];
      end else if (idx == CFG_IDX_CAUSE) begin
        d_out_d = cause_byte;
      end
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      cfg_q          <= CFG_RESET;
      d_out_q        <= 8'hFF;
      d_out_active_q <= 1'b0;
    end else begin
      cfg_q          <= cfg_d;
      d_out_q        <= d_out_d;
      d_out_active_q <= d_out_active_d;
    end
  end

  assign cfg          = cfg_q;
  assign d_out        = d_out_q;
  assign d_out_active = d_out_active_q;

endmodule

// File: rtl/magic_nmi_ctrl.sv
// Magic-ROM controller: arbitrates NMI sources, drives n_nmi, tracks map/unmap from CPU fetches.
// Requests see 2 cycles of sync latency and are only taken on an INT falling edge while IDLE.
module magic_nmi_ctrl
  import magic_nmi_ctrl_pkg::*;
#(
  parameter int                 NSRC       = 2,
  parameter int                 NREGS      = 16,
  parameter logic [NREGS*8-1:0] CFG_RESET  = '0,
  parameter logic [7:0]         CFG_PORT   = 8'hFF,
  parameter logic [15:0]        NMI_VEC    = 16'h0066,
  parameter logic [15:0]        EXIT_ADDR  = 16'hF000,
  parameter logic [15:0]        REENT_ADDR = 16'hF008,
  parameter int                 TMO_W      = 12
) (
  input  logic               clk28,
  input  logic               rst,
  cpu_bus.slave              bus,
  input  logic               n_int,
  input  logic               n_int_next,
  input  logic [NSRC-1:0]    nmi_req,
  output logic               n_nmi,
  output logic               magic_mode,
  output logic               magic_map,
  output logic [NSRC-1:0]    cause,
  output logic [NREGS*8-1:0] cfg,
  output logic [7:0]         d_out,
  output logic               d_out_active
);

  magic_state_t     state_q, state_d;
  logic [NSRC-1:0]  req_s1_q, req_s1_d;
  logic [NSRC-1:0]  req_s2_q, req_s2_d;
  logic             n_nmi_q, n_nmi_d;
  logic             mode_q, mode_d;
  logic             map_q, map_d;
  logic [NSRC-1:0]  cause_q, cause_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [TMO_W-1:0] tmo_inc;
  logic             exit_q, exit_d;

  logic             int_edge;
  logic [NSRC-1:0]  first_req;
  logic [7:0]       cause_byte;
  logic             cfg_cs;

  always_comb begin
    req_s1_d = nmi_req;
    req_s2_d = req_s1_q;
    int_edge = n_int && !n_int_next;
    tmo_inc  = tmo_q + 1'b1;

    // Scan from the top so the lowest-index request wins.
    first_req = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_s2_q[i]) begin
        first_req    = '0;
        first_req[i] = 1'b1;
      end
    end

    cause_byte              = '0;
    cause_byte[NSRC-1:0]    = cause_q;
    cfg_cs = map_q && bus.ioreq && (bus.a[7:0] == CFG_PORT);
  end

  always_comb begin
    state_d = state_q;
    n_nmi_d = n_nmi_q;
    mode_d  = mode_q;
    map_d   = map_q;
    cause_d = cause_q;
    tmo_d   = tmo_q;
    exit_d  = exit_q;

    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (int_edge && (|req_s2_q)) begin
          cause_d = first_req;
          n_nmi_d = 1'b0;
          mode_d  = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        if (bus.m1 && bus.mreq && (bus.a == NMI_VEC)) begin
          n_nmi_d = 1'b1;
          map_d   = 1'b1;
          state_d = MAPPED;
        end else if (tmo_inc == '1) begin
          // CPU never acknowledged (NMI masked or lost): abandon the entry.
          n_nmi_d = 1'b1;
          mode_d  = 1'b0;
          cause_d = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      MAPPED: begin
        if (bus.mreq && bus.rd && (bus.a == EXIT_ADDR)) begin
          mode_d  = 1'b0;
          exit_d  = 1'b1;
          state_d = UNMAP;
        end else if (bus.mreq && bus.rd && (bus.a == REENT_ADDR)) begin
          exit_d  = 1'b0;
          state_d = UNMAP;
        end
      end
      UNMAP: begin
        // Hold the ROM until the triggering read completes.
        if (!bus.mreq) begin
          map_d = 1'b0;
          if (exit_q) begin
            cause_d = '0;
            state_d = IDLE;
          end else begin
            state_d = REENT;
          end
        end
      end
      REENT: begin
        if (bus.m1 && bus.mreq) begin
          map_d   = 1'b1;
          state_d = MAPPED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q  <= MAPPED;
      req_s1_q <= '0;
      req_s2_q <= '0;
      n_nmi_q  <= 1'b1;
      mode_q   <= 1'b1;
      map_q    <= 1'b1;
      cause_q  <= '0;
      tmo_q    <= '0;
      exit_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_s1_q <= req_s1_d;
      req_s2_q <= req_s2_d;
      n_nmi_q  <= n_nmi_d;
      mode_q   <= mode_d;
      map_q    <= map_d;
      cause_q  <= cause_d;
      tmo_q    <= tmo_d;
      exit_q   <= exit_d;
    end
  end

  magic_cfg_regs #(
    .NREGS     (NREGS),
    .CFG_RESET (CFG_RESET)
  ) u_cfg_regs (
    .clk28        (clk28),
    .rst          (rst),
    .cs           (cfg_cs),
    .rd           (bus.rd),
    .wr           (bus.wr),
    .idx          (bus.a[15:8]),
    .wdat         (bus.d),
    .cause_byte   (cause_byte),
    .cfg          (cfg),
    .d_out        (d_out),
    .d_out_active (d_out_active)
  );

  assign n_nmi      = n_nmi_q;
  assign magic_mode = mode_q;
  assign magic_map  = map_q;
  assign cause      = cause_q;

endmodule

// File: tb/tb_magic_nmi_ctrl.sv
// Directed bench for magic_nmi_ctrl with a per-cycle behavioural model and literal spot checks.
module tb_magic_nmi_ctrl;

  localparam int TMO_LIMIT = 4095;

  logic         clk28 = 1'b0;
  logic         rst;
  logic         n_int, n_int_next;
  logic [1:0]   nmi_req;
  logic         n_nmi, magic_mode, magic_map, d_out_active;
  logic [1:0]   cause;
  logic [127:0] cfg;
  logic [7:0]   d_out;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_bus bus ();

  magic_nmi_ctrl dut (
    .clk28        (clk28),
    .rst          (rst),
    .bus          (bus),
    .n_int        (n_int),
    .n_int_next   (n_int_next),
    .nmi_req      (nmi_req),
    .n_nmi        (n_nmi),
    .magic_mode   (magic_mode),
    .magic_map    (magic_map),
    .cause        (cause),
    .cfg          (cfg),
    .d_out        (d_out),
    .d_out_active (d_out_active)
  );

  always #5 clk28 = ~clk28;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_valid = 1'b0;
  logic       m_nmi, m_mode, m_map, m_dact;
  logic [1:0] m_cause, m_s1, m_s2;
  logic [7:0] m_dout;
  logic [7:0] m_cfg [0:15];
  logic       m_idle, m_wait_ack, m_in_rom, m_leaving, m_leave_exit, m_wait_remap;
  int         m_pend_cycles;
  logic [127:0] m_cfg_flat;

  wire       m_cs   = m_map && bus.ioreq && (bus.a[7:0] == 8'hFF);
  wire [7:0] m_idx  = bus.a[15:8];
  wire       m_samp = n_int && !n_int_next;

  always_comb begin
    m_cfg_flat = '0;
    for (int i = 0; i < 16; i++) m_cfg_flat[i*8 +: 8] = m_cfg[i];
  end

  always @(posedge clk28) begin
    if (rst) begin
      m_valid      <= 1'b1;
      m_nmi        <= 1'b1;
      m_mode       <= 1'b1;
      m_map        <= 1'b1;
      m_cause      <= 2'b00;
      m_dact       <= 1'b0;
      m_dout       <= 8'hFF;
      m_s1         <= 2'b00;
      m_s2         <= 2'b00;
      m_idle       <= 1'b0;
      m_wait_ack   <= 1'b0;
      m_in_rom     <= 1'b1;
      m_leaving    <= 1'b0;
      m_leave_exit <= 1'b0;
      m_wait_remap <= 1'b0;
      m_pend_cycles <= 0;
      for (int i = 0; i < 16; i++) m_cfg[i] <= 8'h00;
    end else begin
      m_s1 <= nmi_req;
      m_s2 <= m_s1;
      if (m_cs && bus.wr && (m_idx < 8'd16)) m_cfg[m_idx[3:0]] <= bus.d;
      m_dact <= m_cs && bus.rd;
      m_dout <= !(m_cs && bus.rd) ? 8'hFF :
                (m_idx < 8'd16)   ? m_cfg[m_idx[3:0]] :
                (m_idx == 8'hFE)  ? {6'b0, m_cause} : 8'hFF;
      if (m_idle) begin
        if (m_samp && (m_s2 != 2'b00)) begin
          m_cause       <= m_s2[0] ? 2'b01 : 2'b10;
          m_nmi         <= 1'b0;
          m_mode        <= 1'b1;
          m_idle        <= 1'b0;
          m_wait_ack    <= 1'b1;
          m_pend_cycles <= 0;
        end
      end else if (m_wait_ack) begin
        if (bus.m1 && bus.mreq && (bus.a == 16'h0066)) begin
          m_nmi      <= 1'b1;
          m_map      <= 1'b1;
          m_wait_ack <= 1'b0;
          m_in_rom   <= 1'b1;
        end else if (m_pend_cycles + 1 == TMO_LIMIT) begin
          m_nmi      <= 1'b1;
          m_mode     <= 1'b0;
          m_cause    <= 2'b00;
          m_wait_ack <= 1'b0;
          m_idle     <= 1'b1;
        end else begin
          m_pend_cycles <= m_pend_cycles + 1;
        end
      end else if (m_in_rom) begin
        if (bus.mreq && bus.rd && (bus.a == 16'hF000)) begin
          m_mode       <= 1'b0;
          m_in_rom     <= 1'b0;
          m_leaving    <= 1'b1;
          m_leave_exit <= 1'b1;
        end else if (bus.mreq && bus.rd && (bus.a == 16'hF008)) begin
          m_in_rom     <= 1'b0;
          m_leaving    <= 1'b1;
          m_leave_exit <= 1'b0;
        end
      end else if (m_leaving) begin
        if (!bus.mreq) begin
          m_map     <= 1'b0;
          m_leaving <= 1'b0;
          if (m_leave_exit) begin
            m_idle  <= 1'b1;
            m_cause <= 2'b00;
          end else begin
            m_wait_remap <= 1'b1;
          end
        end
      end else if (m_wait_remap) begin
        if (bus.m1 && bus.mreq) begin
          m_map        <= 1'b1;
          m_wait_remap <= 1'b0;
          m_in_rom     <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk28) begin
    if (m_valid) begin
      chk("model n_nmi", n_nmi, m_nmi);
      chk("model magic_mode", magic_mode, m_mode);
      chk("model magic_map", magic_map, m_map);
      chk("model cause", cause, m_cause);
      chk("model d_out_active", d_out_active, m_dact);
      chk("model d_out", d_out, m_dout);
      chk("model cfg", cfg, m_cfg_flat);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk28);
    #1;
  endtask

  task automatic bus_idle();
    bus.a = 16'h0000; bus.d = 8'h00;
    bus.mreq = 1'b0; bus.ioreq = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.m1 = 1'b0;
  endtask

  task automatic int_edge();
    n_int_next = 1'b0;
    step();
    n_int_next = 1'b1;
  endtask

  task automatic mem_rd(input logic [15:0] addr);
    bus.a = addr; bus.mreq = 1'b1; bus.rd = 1'b1;
    step();
  endtask

  task automatic m1_fetch(input logic [15:0] addr);
    bus.a = addr; bus.mreq = 1'b1; bus.rd = 1'b1; bus.m1 = 1'b1;
    step();
    bus_idle();
  endtask

  task automatic io_wr(input logic [15:0] addr, input logic [7:0] dat);
    bus.a = addr; bus.d = dat; bus.ioreq = 1'b1; bus.wr = 1'b1;
    step();
    bus_idle();
  endtask

  task automatic io_rd(input logic [15:0] addr);
    bus.a = addr; bus.ioreq = 1'b1; bus.rd = 1'b1;
    step();
    bus_idle();
  endtask

  initial begin
    int cnt;
    rst = 1'b1; n_int = 1'b1; n_int_next = 1'b1; nmi_req = 2'b00;
    bus_idle();
    repeat (3) @(posedge clk28);
    #1 rst = 1'b0;
    #1;
    chk("reset n_nmi", n_nmi, 1'b1);
    chk("reset magic_mode", magic_mode, 1'b1);
    chk("reset magic_map", magic_map, 1'b1);
    chk("reset cause", cause, 2'b00);
    chk("reset d_out", d_out, 8'hFF);
    chk("reset d_out_active", d_out_active, 1'b0);
    chk("reset cfg", cfg, 128'h0);
    step();

    // Leave magic mode via exit address.
    mem_rd(16'hF000);
    chk("exit mode", magic_mode, 1'b0);
    chk("exit map held", magic_map, 1'b1);
    bus_idle();
    step();
    chk("exit map dropped", magic_map, 1'b0);

    // NMI entry with both sources requesting.
    nmi_req = 2'b11;
    repeat (3) step();
    int_edge();
    chk("entry n_nmi", n_nmi, 1'b0);
    chk("entry cause", cause, 2'b01);
    chk("entry mode", magic_mode, 1'b1);
    nmi_req = 2'b00;
    step();
    m1_fetch(16'h0066);
    chk("ack n_nmi", n_nmi, 1'b1);
    chk("ack map", magic_map, 1'b1);

    // Config port while mapped.
    io_rd(16'hFEFF);
    chk("cause readback act", d_out_active, 1'b1);
    chk("cause readback", d_out, 8'h01);
    io_wr(16'h03FF, 8'hA5);
    chk("cfg write", cfg[31:24], 8'hA5);
    io_rd(16'h03FF);
    chk("cfg readback", d_out, 8'hA5);
    io_wr(16'h20FF, 8'h5A);
    chk("cfg oob write", cfg, {96'h0, 8'hA5, 24'h0});
    io_rd(16'h20FF);
    chk("oob readback act", d_out_active, 1'b1);
    chk("oob readback", d_out, 8'hFF);

    // Exit, then config access while unmapped.
    mem_rd(16'hF000);
    bus_idle();
    step();
    io_wr(16'h03FF, 8'h3C);
    chk("unmapped write", cfg[31:24], 8'hA5);
    io_rd(16'h03FF);
    chk("unmapped read act", d_out_active, 1'b0);

    // Timeout of an unacknowledged NMI.
    nmi_req = 2'b01;
    repeat (3) step();
    int_edge();
    chk("tmo entry n_nmi", n_nmi, 1'b0);
    nmi_req = 2'b00;
    cnt = 0;
    while (n_nmi === 1'b0 && cnt < 5000) begin
      step();
      cnt++;
    end
    chk("tmo cycles", cnt, TMO_LIMIT);
    chk("tmo mode", magic_mode, 1'b0);
    chk("tmo cause", cause, 2'b00);

    // Entry from source 1, then re-entry path.
    nmi_req = 2'b10;
    repeat (3) step();
    int_edge();
    chk("src1 cause", cause, 2'b10);
    m1_fetch(16'h0066);
    io_rd(16'hFEFF);
    chk("src1 readback", d_out, 8'h02);
    mem_rd(16'hF008);
    chk("reent map held", magic_map, 1'b1);
    bus_idle();
    step();
    chk("reent unmapped", magic_map, 1'b0);
    chk("reent mode", magic_mode, 1'b1);
    m1_fetch(16'h1234);
    chk("reent remap", magic_map, 1'b1);
    chk("reent mode kept", magic_mode, 1'b1);

    // Requests ignored while mapped.
    int_edge();
    chk("ignored req", n_nmi, 1'b1);

    // Exit, re-enter PEND, then reset mid-operation.
    mem_rd(16'hF000);
    bus_idle();
    step();
    int_edge();
    chk("pend before rst", n_nmi, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst n_nmi", n_nmi, 1'b1);
    chk("midrst map", magic_map, 1'b1);
    chk("midrst mode", magic_mode, 1'b1);
    chk("midrst cfg", cfg, 128'h0);
    nmi_req = 2'b00;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
